rex_game_ctrl: RTL and testbench

- Game sequencer for the runner display. Once per frame tick it advances the rex jump physics and the obstacle scroll, detects rex/obstacle collision, and keeps score.
- Owns the game state machine. Drives the rex_down, obstacle_left and game_state values that the pixel decider consumes.
- Updates only on frame_tick, so the decider sees values that are stable for a whole frame.

---
 rtl/rex_game_ctrl.sv | 97 +++++++++
 tb/tb_rex_game_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/rex_game_ctrl.sv
// rex_game_ctrl: runner game sequencer - jump physics, obstacle scroll, collision and score,
// advanced once per frame_tick so the pixel decider sees values stable for a whole frame.
module rex_game_ctrl #(
  parameter int SPAWN_X    = 128,
  parameter int JUMP_V     = 7,
  parameter int GRAVITY    = 1,
  parameter int SPEED_INIT = 2,
  parameter int SPEED_MAX  = 4,
  parameter int REX_LEFT   = 8,
  parameter int REX_W      = 24,
  parameter int REX_H      = 23,
  parameter int OBS_W      = 16,
  parameter int OBS_H      = 22
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        frame_tick,
  input  logic        btn_start,
  input  logic        btn_jump,
  output logic [15:0] rex_down,
  output logic [15:0] obstacle_left,
  output logic [1:0]  game_state,
  output logic [15:0] score,
  output logic        collide
);
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, OVER = 2'b10, BAD = 2'b11} state_t;
  state_t state, state_nxt;
  logic [2:0] start_sync, jump_sync;
  logic start_edge, jump_edge, hit, grounded, load, jump_pending;
  logic signed [7:0] vel;
  logic signed [16:0] sum;
  logic [15:0] speed, speed_calc;
  // [0],[1] form the synchronizer, [2] is the previous synchronized level for edge detect
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      start_sync <= '0;
      jump_sync  <= '0;
    end else begin
      start_sync <= {start_sync[1:0], btn_start};
      jump_sync  <= {jump_sync[1:0], btn_jump};
    end
  assign start_edge = start_sync[1] & ~start_sync[2];
  assign jump_edge  = jump_sync[1] & ~jump_sync[2];
  assign hit = obstacle_left < 16'(REX_LEFT + REX_W) && (obstacle_left + 16'(OBS_W)) > 16'(REX_LEFT)
            && rex_down < 16'(OBS_H) && (rex_down + 16'(REX_H)) > 16'd0;
  assign grounded   = rex_down == 16'd0 && vel == 8'sd0;
  assign sum        = $signed({1'b0, rex_down}) + $signed({{9{vel[7]}}, vel});
  assign speed_calc = 16'(SPEED_INIT) + {9'd0, score[15:9]};
  assign load       = (state == IDLE || state == OVER) && start_edge;
  assign game_state = state;
  always_comb begin
    state_nxt = state;
    state_nxt = state == BAD ? IDLE : state == RUN ? (hit ? OVER : RUN) : (load ? RUN : state);
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      rex_down      <= '0;
      vel           <= '0;
      obstacle_left <= 16'(SPAWN_X);
      score         <= '0;
      collide       <= 1'b0;
      speed         <= 16'(SPEED_INIT);
      jump_pending  <= 1'b0;
    end else if (load) begin
      rex_down      <= '0;
      vel           <= '0;
      obstacle_left <= 16'(SPAWN_X);
      score         <= '0;
      collide       <= 1'b0;
      speed         <= 16'(SPEED_INIT);
      jump_pending  <= 1'b0;
    end else if (state == RUN) begin
      if (hit) collide <= 1'b1;
      else begin
        // a tick consumes whatever jump was pending; an edge arriving now waits for the next tick
        jump_pending <= (jump_pending & ~frame_tick) | jump_edge;
        if (frame_tick) begin
          if (grounded && jump_pending) vel <= 8'(JUMP_V);
          else if (!grounded) begin
            if (sum <= 17'sd0) begin
              rex_down <= '0;
              vel      <= '0;
            end else begin
              rex_down <= sum[15:0];
              vel      <= vel - 8'(GRAVITY);
            end
          end
          obstacle_left <= obstacle_left <= speed ? 16'(SPAWN_X) : obstacle_left - speed;
          score         <= &score ? score : score + 16'd1;
          speed         <= speed_calc > 16'(SPEED_MAX) ? 16'(SPEED_MAX) : speed_calc;
        end
      end
    end
endmodule

// File: tb/tb_rex_game_ctrl.sv
// tb_rex_game_ctrl: random and directed stimulus against a frame-level game model; instance b
// runs faster obstacles so a jump scheduler can survive long enough to exercise speed-up.
module tb_rex_game_ctrl;
  logic clk = 0, rstn = 1;
  logic tick_a = 0, start_a = 0, jump_a = 0, tick_b = 0, start_b = 0, jump_b = 0;
  logic [15:0] rex_a, ob_a, sc_a, rex_b, ob_b, sc_b;
  logic [1:0] gs_a, gs_b;
  logic col_a, col_b;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;

  rex_game_ctrl u_a (.clk(clk), .rstn(rstn), .frame_tick(tick_a), .btn_start(start_a), .btn_jump(jump_a),
    .rex_down(rex_a), .obstacle_left(ob_a), .game_state(gs_a), .score(sc_a), .collide(col_a));
  rex_game_ctrl #(.SPEED_INIT(4), .SPEED_MAX(6)) u_b (.clk(clk), .rstn(rstn), .frame_tick(tick_b),
    .btn_start(start_b), .btn_jump(jump_b), .rex_down(rex_b), .obstacle_left(ob_b), .game_state(gs_b),
    .score(sc_b), .collide(col_b));

  typedef struct { int st, rex, vel, ob, sc, spd, si, sm; bit jp, col; bit [2:0] hs, hj; } mdl_t;
  mdl_t m_a, m_b;

  function automatic mdl_t mreset(int si, int sm);
    mdl_t m;
    m = '{default: 0};
    m.ob = 128; m.spd = si; m.si = si; m.sm = sm;
    return m;
  endfunction

  function automatic bit hit(mdl_t m);
    return m.ob < 32 && m.ob + 16 > 8 && m.rex < 22;
  endfunction

  // one frame of game rules: jump launch or ballistic step, scroll, score, speed from old score
  function automatic mdl_t phys(mdl_t m);
    int sum;
    if (m.rex == 0 && m.vel == 0) begin
      if (m.jp) m.vel = 7;
    end else begin
      sum = m.rex + m.vel;
      if (sum <= 0) begin m.rex = 0; m.vel = 0; end
      else begin m.rex = sum; m.vel = m.vel - 1; end
    end
    m.ob  = (m.ob <= m.spd) ? 128 : m.ob - m.spd;
    m.spd = (m.si + m.sc / 512 > m.sm) ? m.sm : m.si + m.sc / 512;
    m.sc  = (m.sc < 65535) ? m.sc + 1 : m.sc;
    m.jp  = 0;
    return m;
  endfunction

  // buttons: a press is acted on at the third clock edge after the pin is first sampled high
  function automatic mdl_t step(mdl_t m, bit sp, bit jpn, bit tk);
    bit se, je;
    mdl_t r;
    se = m.hs[1] && !m.hs[2];
    je = m.hj[1] && !m.hj[2];
    m.hs = {m.hs[1:0], sp};
    m.hj = {m.hj[1:0], jpn};
    if (m.st == 3) m.st = 0;
    else if (m.st == 1) begin
      if (hit(m)) begin m.st = 2; m.col = 1; end
      else begin
        if (tk) m = phys(m);
        m.jp = m.jp | je;
      end
    end else if (se) begin
      r = mreset(m.si, m.sm);
      r.hs = m.hs; r.hj = m.hj; r.st = 1;
      m = r;
    end
    return m;
  endfunction

  // true when launching on the next tick clears the approaching obstacle and lands safely
  function automatic bit jump_ok(mdl_t m);
    bit ent = 0;
    m.jp = 1;
    for (int i = 0; i < 16; i++) begin
      m = phys(m);
      if (hit(m)) return 0;
      if (m.ob < 32) ent = 1;
    end
    return ent;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rstn)
    if (!rstn) begin
      m_a <= mreset(2, 4);
      m_b <= mreset(4, 6);
    end else begin
      m_a <= step(m_a, start_a, jump_a, tick_a);
      m_b <= step(m_b, start_b, jump_b, tick_b);
    end

  always @(negedge clk) begin
    chk("a_state", gs_a, m_a.st); chk("a_rex", rex_a, m_a.rex); chk("a_ob", ob_a, m_a.ob);
    chk("a_score", sc_a, m_a.sc); chk("a_collide", col_a, m_a.col);
    chk("b_state", gs_b, m_b.st); chk("b_rex", rex_b, m_b.rex); chk("b_ob", ob_b, m_b.ob);
    chk("b_score", sc_b, m_b.sc); chk("b_collide", col_b, m_b.col);
  end

  task automatic tick_a_t();
    tick_a = 1;
    @(negedge clk);
    tick_a = 0;
    repeat ($urandom_range(1, 4)) @(negedge clk);
  endtask

  task automatic press_a(input bit s, input int hold);
    if (s) start_a = 1; else jump_a = 1;
    repeat (hold) @(negedge clk);
    start_a = 0; jump_a = 0;
    @(negedge clk);
  endtask

  task automatic chk_reset_a(input string nm);
    chk({nm, "_rex"}, rex_a, 0); chk({nm, "_ob"}, ob_a, 128); chk({nm, "_state"}, gs_a, 0);
    chk({nm, "_score"}, sc_a, 0); chk({nm, "_collide"}, col_a, 0);
  endtask

  task automatic rand_a();
    repeat (400) begin
      int r = $urandom_range(0, 9);
      if (r < 6) tick_a_t();
      else if (r < 8) press_a(0, $urandom_range(1, 5));
      else if (r == 8) press_a(1, $urandom_range(1, 3));
      else repeat ($urandom_range(1, 6)) @(negedge clk);
    end
  endtask

  task automatic run_b();
    int thr[4] = '{100, 600, 1100, 1600};
    int stp[4] = '{4, 5, 6, 6};
    bit sdone[4] = '{0, 0, 0, 0};
    bit seen_low = 0, pass_done = 0;
    start_b = 1;
    repeat (3) @(negedge clk);
    start_b = 0;
    repeat (3) @(negedge clk);
    chk("b_start", gs_b, 1);
    for (int it = 0; it < 3000 && m_b.st == 1 && m_b.sc < 1700; it++) begin
      int p = m_b.sc;
      int obb = ob_b;
      bit run = gs_b == 1;
      tick_b = 1;
      @(negedge clk);
      tick_b = 0;
      for (int k = 0; k < 4; k++)
        if (!sdone[k] && run && p >= thr[k] && obb > 6) begin
          chk($sformatf("b_step_%0d", thr[k]), obb - int'(ob_b), stp[k]);
          sdone[k] = 1;
        end
      if (!pass_done) begin
        if (seen_low && ob_b == 128) begin
          chk("b_pass_min", obb, 4);
          chk("b_pass_collide", col_b, 0);
          pass_done = 1;
        end
        if (ob_b < 32) seen_low = 1;
      end
      if (m_b.st == 1 && m_b.rex == 0 && m_b.vel == 0 && !m_b.jp && jump_ok(m_b)) jump_b = 1;
      repeat (3) @(negedge clk);
      jump_b = 0;
      repeat ($urandom_range(2, 5)) @(negedge clk);
    end
    chk("b_survived", gs_b, 1);
    chk("b_score_reached", sc_b >= 16'd1700, 1);
  endtask

  initial begin
    int jexp[16] = '{0, 7, 13, 18, 22, 25, 27, 28, 28, 27, 25, 22, 18, 13, 7, 0};
    #1 rstn = 0;
    @(negedge clk);
    chk_reset_a("a_rst");
    @(negedge clk);
    rstn = 1;
    @(negedge clk);
    press_a(1, 3);
    chk("a_run", gs_a, 1); chk("a_start_ob", ob_a, 128); chk("a_start_score", sc_a, 0);
    repeat (10) tick_a_t();
    chk("a_ob_10", ob_a, 108); chk("a_score_10", sc_a, 10);
    press_a(0, 3);
    for (int i = 0; i < 16; i++) begin
      tick_a_t();
      chk($sformatf("a_jump_%0d", i), rex_a, jexp[i]);
      if (i == 2) press_a(0, 2);
    end
    repeat (2) begin
      tick_a_t();
      chk("a_rex_landed", rex_a, 0);
    end
    chk("a_ob_28", ob_a, 72);
    for (int i = 0; i < 40 && gs_a != 2; i++) tick_a_t();
    chk("a_hit_collide", col_a, 1); chk("a_hit_state", gs_a, 2);
    chk("a_hit_ob", ob_a, 30); chk("a_hit_score", sc_a, 49);
    repeat (3) tick_a_t();
    chk("a_frozen_ob", ob_a, 30); chk("a_frozen_score", sc_a, 49);
    press_a(1, 3);
    chk("a_restart_state", gs_a, 1); chk("a_restart_collide", col_a, 0);
    chk("a_restart_ob", ob_a, 128); chk("a_restart_score", sc_a, 0);
    press_a(0, 3);
    repeat (6) tick_a_t();
    chk("a_midjump_rex", rex_a, 25);
    @(negedge clk);
    #2 rstn = 0;
    #1 chk_reset_a("a_async_rst");
    @(negedge clk);
    @(negedge clk);
    rstn = 1;
    @(negedge clk);
    press_a(1, 3);
    chk("a_clean_state", gs_a, 1); chk("a_clean_rex", rex_a, 0);
    repeat (3) tick_a_t();
    chk("a_clean_rex3", rex_a, 0); chk("a_clean_score3", sc_a, 3);
    press_a(1, 3);
    chk("a_start_in_run", sc_a, 3);
    fork
      rand_a();
      run_b();
    join
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not complete, %0d compared / %0d mismatched so far", n_cmp, n_bad);
    $fatal(1);
  end
endmodule
